// File: rtl/seg7_scan_drv_pkg.sv
// Shared constants for the 7-segment display back-end: hex glyph table,
// blank/off codes and default counter widths.
package seg7_scan_drv_pkg;

  localparam int SCAN_W_DEF  = 17;
  localparam int BLINK_W_DEF = 25;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry n is hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_scan_drv_hex7seg_dec.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex7seg_dec
  import seg7_scan_drv_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the glyph for this nibble.
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Eight-digit common-anode 7-segment scan driver with per-frame input
// snapshot, decimal points, blink and leading-zero blanking.
module seg7_scan_drv
  import seg7_scan_drv_pkg::*;
#(
  parameter int SCAN_W  = SCAN_W_DEF,
  parameter int BLINK_W = BLINK_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        lz_en,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  logic [SCAN_W-1:0]  presc;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic [31:0]        sh_num;
  logic [7:0]         sh_point;
  logic [7:0]         sh_le;
  logic               load_pend;

  logic               tick;
  logic               snap;
  logic               blink_off;
  logic               upper_zero;
  logic [7:0]         lz_blank;
  logic [3:0]         nib;
  logic [6:0]         seg7;
  logic               dp;
  logic               blank;
  logic [7:0]         seg_next;
  logic [7:0]         an_next;

  // Scan tick, frame-boundary snapshot strobe and blink phase.
  always_comb begin
    tick      = &presc;
    snap      = (tick && (idx == 3'd7)) || load_pend;
    blink_off = blink_cnt[BLINK_W-1];
  end

  // Free-running prescaler, digit index and blink counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      presc     <= presc + SCAN_W'(1);
      blink_cnt <= blink_cnt + BLINK_W'(1);
      if (tick) idx <= idx + 3'd1;
    end
  end

  // Shadow copy of the inputs, refreshed only at frame wrap or right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_num    <= '0;
      sh_point  <= '0;
      sh_le     <= '0;
      load_pend <= 1'b1;
    end else begin
      load_pend <= 1'b0;
      if (snap) begin
        sh_num   <= Disp_num;
        sh_point <= point_in;
        sh_le    <= LE_in;
      end
    end
  end

  // Digit i is blanked when every nibble from i upward is zero; digit 0 never is.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = 7; i >= 1; i--) begin
      upper_zero  = upper_zero && (sh_num[4*i +: 4] == 4'd0);
      lz_blank[i] = lz_en && upper_zero;
    end
  end

  hex7seg_dec u_dec (
    .nib (nib),
    .seg (seg7)
  );

  // Current digit's glyph, point and blanking; blink also hides the point.
  always_comb begin
    nib      = sh_num[{idx, 2'b00} +: 4];
    dp       = ~sh_point[idx];
    blank    = (sh_le[idx] && blink_off) || lz_blank[idx];
    seg_next = blank ? SEG_BLANK : {dp, seg7};
    an_next  = EN ? ~(8'b1 << idx) : AN_OFF;
  end

  // Anode and segment pins register together so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN  <= AN_OFF;
      SEG <= SEG_BLANK;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Scoreboard bench for seg7_scan_drv with a 4-cycle digit period and a
// 16-cycle blink period.
module tb_seg7_scan_drv;

  localparam int SCAN_W  = 2;
  localparam int BLINK_W = 4;

  // Hand-computed SEG per digit, byte d = digit d.
  localparam logic [63:0] TAB_NUM = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
  localparam logic [63:0] TAB_F   = {8{8'h8E}};
  localparam logic [63:0] TAB_PB  = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hFF, 8'hF8, 8'h00};
  localparam logic [63:0] TAB_LZA = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hC0, 8'hC0};
  localparam logic [63:0] TAB_LZ0 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic        lz_en;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  LE_in;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .SCAN_W  (SCAN_W),
    .BLINK_W (BLINK_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .lz_en    (lz_en),
    .Disp_num (Disp_num),
    .point_in (point_in),
    .LE_in    (LE_in),
    .AN       (AN),
    .SEG      (SEG)
  );

  // Monitor: every edge that has an expectation is checked at the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (AN !== e.an || SEG !== e.seg) begin
          n_miss++;
          $display("FAIL %s: got AN=%h SEG=%h, want AN=%h SEG=%h", e.name, AN, SEG, e.an, e.seg);
        end
      end
    end
  end

  task automatic expect_edge(input logic [7:0] an, input logic [7:0] seg, input string name);
    @(posedge clk);
    sb_q.push_back('{an: an, seg: seg, name: name});
    #1;
  endtask

  // One scan frame: digit d shown for 4 edges. skip drops the first edges of
  // digit 0, chg_d swaps Disp_num as digit chg_d begins, stop_d ends early.
  task automatic run_frame(input logic [63:0] tab, input logic [7:0] en_mask,
                           input int skip, input int chg_d, input logic [31:0] chg_num,
                           input int stop_d, input string name);
    logic [7:0] an;
    for (int d = 0; d < 8; d++) begin
      if (d == stop_d) break;
      for (int r = 0; r < 4; r++) begin
        if (d == 0 && r < skip) continue;
        if (d == chg_d && r == 0) Disp_num = chg_num;
        EN = en_mask[d];
        an = 8'hFF;
        if (en_mask[d]) an[d] = 1'b0;
        expect_edge(an, tab[8*d +: 8], name);
      end
    end
  endtask

  // Stimulus.
  initial begin
    rst      = 1'b1;
    EN       = 1'b1;
    lz_en    = 1'b0;
    Disp_num = 32'h12345678;
    point_in = 8'h00;
    LE_in    = 8'h00;

    repeat (3) expect_edge(8'hFF, 8'hFF, "reset");
    rst = 1'b0;
    // Shadow still holds its reset value on this edge.
    expect_edge(8'hFE, 8'hC0, "first_after_rst");
    run_frame(TAB_NUM, 8'hFF, 1, 8, 32'h0, 8, "scan0");
    run_frame(TAB_NUM, 8'hFF, 0, 3, 32'hFFFFFFFF, 8, "snap_hold");

    Disp_num = 32'h12345678;
    point_in = 8'h05;
    LE_in    = 8'h06;
    run_frame(TAB_F, 8'hFF, 0, 8, 32'h0, 8, "snap_new");

    Disp_num = 32'h00000A00;
    point_in = 8'h00;
    LE_in    = 8'h00;
    lz_en    = 1'b1;
    run_frame(TAB_PB, 8'hFF, 0, 8, 32'h0, 8, "pt_blink");

    Disp_num = 32'h00000000;
    run_frame(TAB_LZA, 8'hFF, 0, 8, 32'h0, 8, "lz_a00");

    Disp_num = 32'h12345678;
    run_frame(TAB_LZ0, 8'hFF, 0, 8, 32'h0, 8, "lz_zero");

    lz_en = 1'b0;
    run_frame(TAB_NUM, 8'hE3, 0, 8, 32'h0, 8, "en_off");
    run_frame(TAB_NUM, 8'hFF, 0, 8, 32'h0, 5, "pre_rst");

    rst = 1'b1;
    expect_edge(8'hFF, 8'hFF, "rst_mid");
    rst = 1'b0;
    expect_edge(8'hFE, 8'hC0, "restart");
    run_frame(TAB_NUM, 8'hFF, 1, 8, 32'h0, 8, "after_rst");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
